id_ex_reg: RTL and testbench

Pipeline register and operand-forwarding stage sitting directly upstream of the ALU in the pipelined MIPS datapath. It captures decoded instruction fields from ID each cycle and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU's `ALUCtl`, `A` and `B` inputs and carries control/destination fields on toward EX/MEM. It supports stall (hold) and flush (bubble), and flags load-use hazards to the hazard unit.

---
 rtl/id_ex_reg.sv | 143 ++++++++++++++
 tb/tb_id_ex_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB.
// Supports stall (hold, refreshing operands with forwarded values) and flush
// (bubble). Flags load-use hazards combinationally to the hazard unit.
module id_ex_reg #(
   parameter int WIDTH = 32,
   parameter int RW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Stall,
   input  logic             Flush,
   input  logic             InValid,
   input  logic [3:0]       InALUCtl,
   input  logic [WIDTH-1:0] InRsData,
   input  logic [WIDTH-1:0] InRtData,
   input  logic [WIDTH-1:0] InImm,
   input  logic [RW-1:0]    InRs,
   input  logic [RW-1:0]    InRt,
   input  logic [RW-1:0]    InRd,
   input  logic             InALUSrc,
   input  logic             InRegDst,
   input  logic             InRegWrite,
   input  logic             InMemRead,
   input  logic             InMemWrite,
   input  logic             InMemToReg,
   input  logic             InBranch,
   input  logic             ExMemRegWrite,
   input  logic [RW-1:0]    ExMemRd,
   input  logic [WIDTH-1:0] ExMemALUOut,
   input  logic             MemWbRegWrite,
   input  logic [RW-1:0]    MemWbRd,
   input  logic [WIDTH-1:0] MemWbData,
   output logic [3:0]       ALUCtl,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] StoreData,
   output logic [RW-1:0]    DestReg,
   output logic             Valid,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemToReg,
   output logic             Branch,
   output logic             LoadUseHazard
);

   typedef struct packed {
      logic             valid;
      logic [3:0]       alu_ctl;
      logic [WIDTH-1:0] rs_data;
      logic [WIDTH-1:0] rt_data;
      logic [WIDTH-1:0] imm;
      logic [RW-1:0]    rs;
      logic [RW-1:0]    rt;
      logic [RW-1:0]    dest;
      logic             alu_src;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             mem_to_reg;
      logic             branch;
   } idex_t;

   idex_t            st_q, st_d;
   logic [WIDTH-1:0] fwd_rs, fwd_rt;

   // EX/MEM is the youngest producer so it wins; $zero is never forwarded.
   function automatic logic [WIDTH-1:0] fwd_sel(
      input logic [RW-1:0]    idx,
      input logic [WIDTH-1:0] reg_val,
      input logic             ex_we,
      input logic [RW-1:0]    ex_rd,
      input logic [WIDTH-1:0] ex_val,
      input logic             wb_we,
      input logic [RW-1:0]    wb_rd,
      input logic [WIDTH-1:0] wb_val
   );
      logic [WIDTH-1:0] r;
      r = reg_val;
      if (ex_we && ex_rd != '0 && ex_rd == idx)      r = ex_val;
      else if (wb_we && wb_rd != '0 && wb_rd == idx) r = wb_val;
      return r;
   endfunction

   // Per-operand forwarding muxes
   always_comb begin
      fwd_rs = fwd_sel(st_q.rs, st_q.rs_data, ExMemRegWrite, ExMemRd, ExMemALUOut,
                       MemWbRegWrite, MemWbRd, MemWbData);
      fwd_rt = fwd_sel(st_q.rt, st_q.rt_data, ExMemRegWrite, ExMemRd, ExMemALUOut,
                       MemWbRegWrite, MemWbRd, MemWbData);
   end

   // Next state: flush > stall > load. A stall refreshes the operands with
   // their forwarded values so a result survives its producer retiring.
   always_comb begin
      st_d = st_q;
      if (Flush) begin
         st_d = '0;
      end else if (Stall) begin
         st_d.rs_data = fwd_rs;
         st_d.rt_data = fwd_rt;
      end else begin
         st_d.valid      = InValid;
         st_d.alu_ctl    = InALUCtl;
         st_d.rs_data    = InRsData;
         st_d.rt_data    = InRtData;
         st_d.imm        = InImm;
         st_d.rs         = InRs;
         st_d.rt         = InRt;
         st_d.dest       = InRegDst ? InRd : InRt;
         st_d.alu_src    = InALUSrc;
         st_d.reg_write  = InRegWrite;
         st_d.mem_read   = InMemRead;
         st_d.mem_write  = InMemWrite;
         st_d.mem_to_reg = InMemToReg;
         st_d.branch     = InBranch;
      end
   end

   // Pipeline register, async clear to a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q <= '0;
      else        st_q <= st_d;
   end

   // Outputs and load-use detection
   always_comb begin
      ALUCtl        = st_q.alu_ctl;
      A             = fwd_rs;
      B             = st_q.alu_src ? st_q.imm : fwd_rt;
      StoreData     = fwd_rt;
      DestReg       = st_q.dest;
      Valid         = st_q.valid;
      RegWrite      = st_q.reg_write;
      MemRead       = st_q.mem_read;
      MemWrite      = st_q.mem_write;
      MemToReg      = st_q.mem_to_reg;
      Branch        = st_q.branch;
      LoadUseHazard = st_q.valid && st_q.mem_read && (st_q.dest != '0) && InValid &&
                      ((st_q.dest == InRs) || (st_q.dest == InRt));
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the stage.
module tb_id_ex_reg;
   localparam int W = 32;
   localparam int R = 5;

   logic clk = 0, rst_n = 0;
   logic Stall = 0, Flush = 0, InValid = 0;
   logic [3:0] InALUCtl = 0;
   logic [W-1:0] InRsData = 0, InRtData = 0, InImm = 0;
   logic [R-1:0] InRs = 0, InRt = 0, InRd = 0;
   logic InALUSrc = 0, InRegDst = 0, InRegWrite = 0, InMemRead = 0;
   logic InMemWrite = 0, InMemToReg = 0, InBranch = 0;
   logic ExMemRegWrite = 0, MemWbRegWrite = 0;
   logic [R-1:0] ExMemRd = 0, MemWbRd = 0;
   logic [W-1:0] ExMemALUOut = 0, MemWbData = 0;
   logic [3:0] ALUCtl;
   logic [W-1:0] A, B, StoreData;
   logic [R-1:0] DestReg;
   logic Valid, RegWrite, MemRead, MemWrite, MemToReg, Branch, LoadUseHazard;

   always #5 clk = ~clk;

   id_ex_reg #(.WIDTH(W), .RW(R)) dut (
      .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .InValid(InValid),
      .InALUCtl(InALUCtl), .InRsData(InRsData), .InRtData(InRtData), .InImm(InImm),
      .InRs(InRs), .InRt(InRt), .InRd(InRd), .InALUSrc(InALUSrc), .InRegDst(InRegDst),
      .InRegWrite(InRegWrite), .InMemRead(InMemRead), .InMemWrite(InMemWrite),
      .InMemToReg(InMemToReg), .InBranch(InBranch),
      .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemALUOut(ExMemALUOut),
      .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
      .ALUCtl(ALUCtl), .A(A), .B(B), .StoreData(StoreData), .DestReg(DestReg),
      .Valid(Valid), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemToReg(MemToReg), .Branch(Branch), .LoadUseHazard(LoadUseHazard));

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: the instruction currently held in EX
   typedef struct {
      bit v; bit [3:0] ctl; bit [31:0] rsd, rtd, imm; bit [4:0] rs, rt, dst;
      bit src, rw, mr, mw, m2r, br;
   } m_t;
   m_t m;

   function automatic bit [31:0] fwd(input bit [4:0] idx, input bit [31:0] regv);
      if (idx != 0 && ExMemRegWrite && ExMemRd == idx) return ExMemALUOut;
      if (idx != 0 && MemWbRegWrite && MemWbRd == idx) return MemWbData;
      return regv;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || Flush) m = '{default: 0};
      else if (Stall) begin
         m.rsd = fwd(m.rs, m.rsd);
         m.rtd = fwd(m.rt, m.rtd);
      end else begin
         m.v = InValid; m.ctl = InALUCtl; m.rsd = InRsData; m.rtd = InRtData;
         m.imm = InImm; m.rs = InRs; m.rt = InRt; m.dst = InRegDst ? InRd : InRt;
         m.src = InALUSrc; m.rw = InRegWrite; m.mr = InMemRead; m.mw = InMemWrite;
         m.m2r = InMemToReg; m.br = InBranch;
      end
   end

   // Every-cycle compare against the model
   always @(negedge clk) begin
      bit [31:0] frt;
      frt = fwd(m.rt, m.rtd);
      chk("ALUCtl", {28'd0, ALUCtl}, {28'd0, m.ctl});
      chk("A", A, fwd(m.rs, m.rsd));
      chk("B", B, m.src ? m.imm : frt);
      chk("StoreData", StoreData, frt);
      chk("DestReg", {27'd0, DestReg}, {27'd0, m.dst});
      chk("ctrl", {26'd0, Valid, RegWrite, MemRead, MemWrite, MemToReg, Branch},
          {26'd0, m.v, m.rw, m.mr, m.mw, m.m2r, m.br});
      chk("LoadUseHazard", {31'd0, LoadUseHazard},
          {31'd0, m.v && m.mr && m.dst != 0 && InValid && (m.dst == InRs || m.dst == InRt)});
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clr_in();
      {Stall, Flush, InValid, InALUCtl, InRsData, InRtData, InImm, InRs, InRt, InRd} = '0;
      {InALUSrc, InRegDst, InRegWrite, InMemRead, InMemWrite, InMemToReg, InBranch} = '0;
      {ExMemRegWrite, ExMemRd, ExMemALUOut, MemWbRegWrite, MemWbRd, MemWbData} = '0;
   endtask

   task automatic rand_in();
      bit wide;
      wide = ($urandom_range(0, 3) == 0);
      Stall = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      InValid = $urandom; InALUCtl = 4'($urandom);
      InRsData = $urandom; InRtData = $urandom; InImm = $urandom;
      InRs = wide ? 5'($urandom) : 5'($urandom_range(0, 3));
      InRt = wide ? 5'($urandom) : 5'($urandom_range(0, 3));
      InRd = 5'($urandom_range(0, 3));
      {InALUSrc, InRegDst, InRegWrite, InMemRead, InMemWrite, InMemToReg, InBranch} = 7'($urandom);
      ExMemRegWrite = $urandom; ExMemRd = 5'($urandom_range(0, 3)); ExMemALUOut = $urandom;
      MemWbRegWrite = $urandom; MemWbRd = 5'($urandom_range(0, 3)); MemWbData = $urandom;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst Valid", {31'd0, Valid}, 32'd0);
      chk("rst ALUCtl", {28'd0, ALUCtl}, 32'd0);
      rst_n = 1;

      // Some traffic, then asynchronous reset mid-cycle
      repeat (5) begin step(); rand_in(); Flush = 0; Stall = 0; InValid = 1; InRegWrite = 1; InRegDst = 1; InRd = 5'd3; end
      step(); clr_in();
      #1 rst_n = 0;
      #1;
      chk("async Valid", {31'd0, Valid}, 32'd0);
      chk("async RegWrite", {31'd0, RegWrite}, 32'd0);
      chk("async DestReg", {27'd0, DestReg}, 32'd0);
      chk("async ALUCtl", {28'd0, ALUCtl}, 32'd0);
      @(negedge clk); rst_n = 1;

      // ADD rs=1 (5), rt=2 (7)
      step();
      InValid = 1; InALUCtl = 4'b1010; InRs = 1; InRt = 2; InRd = 3; InRsData = 5; InRtData = 7;
      InRegDst = 1; InRegWrite = 1;
      step(); clr_in(); #1;
      chk("add ALUCtl", {28'd0, ALUCtl}, 32'ha);
      chk("add A", A, 32'd5);
      chk("add B", B, 32'd7);
      chk("add DestReg", {27'd0, DestReg}, 32'd3);

      // EX/MEM forward and priority over MEM/WB
      InValid = 1; InRs = 3; InRsData = 32'h99; InALUCtl = 4'b1010;
      step(); clr_in();
      ExMemRegWrite = 1; ExMemRd = 3; ExMemALUOut = 32'h10; #1;
      chk("exmem A", A, 32'h10);
      MemWbRegWrite = 1; MemWbRd = 3; MemWbData = 32'h20; #1;
      chk("prio A", A, 32'h10);
      ExMemRegWrite = 0; #1;
      chk("memwb A", A, 32'h20);

      // $zero guard
      step(); clr_in(); InValid = 1; InRs = 0; InRsData = 0;
      step(); clr_in();
      ExMemRegWrite = 1; ExMemRd = 0; ExMemALUOut = 32'hFF;
      MemWbRegWrite = 1; MemWbRd = 0; MemWbData = 32'hEE; #1;
      chk("zero A", A, 32'h0);

      // Stall captures a forwarded value that then retires
      step(); clr_in(); InValid = 1; InRt = 4; InRtData = 32'h1111;
      step(); clr_in();
      MemWbRegWrite = 1; MemWbRd = 4; MemWbData = 32'h1234; Stall = 1; #1;
      chk("stall fwd B", B, 32'h1234);
      step(); MemWbRegWrite = 0; #1;
      chk("stall hold B", B, 32'h1234);
      chk("stall hold StoreData", StoreData, 32'h1234);

      // Load-use hazard, then flush (with stall: flush wins)
      step(); clr_in(); InValid = 1; InMemRead = 1; InRegWrite = 1; InMemToReg = 1; InRt = 8;
      step(); clr_in(); InValid = 1; InRs = 8; InRt = 1; InRegWrite = 1; InMemWrite = 1; #1;
      chk("loaduse", {31'd0, LoadUseHazard}, 32'd1);
      Flush = 1; Stall = 1;
      step(); clr_in(); #1;
      chk("flush ctrl", {26'd0, Valid, RegWrite, MemRead, MemWrite, MemToReg, Branch}, 32'd0);

      // Immediate path
      InValid = 1; InALUSrc = 1; InImm = 32'hFFFFFFFC; InALUCtl = 4'b1010; InRegDst = 0;
      InRt = 9; InRd = 12; InRtData = 32'h77; InRegWrite = 1;
      step(); clr_in();
      MemWbRegWrite = 1; MemWbRd = 9; MemWbData = 32'hABCD; #1;
      chk("imm B", B, 32'hFFFFFFFC);
      chk("imm DestReg", {27'd0, DestReg}, 32'd9);
      chk("imm StoreData", StoreData, 32'hABCD);

      // Randomized traffic with occasional asynchronous reset
      for (int i = 0; i < 400; i++) begin
         step();
         rand_in();
         if ($urandom_range(0, 49) == 0) begin
            #1 rst_n = 0;
            @(negedge clk); rst_n = 1;
         end
      end

      step();
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
